stream_width_packer: RTL and testbench

STREAM_WIDTH_PACKER -- requirements
Module: stream_width_packer

---
 rtl/stream_width_packer_pkg.sv | 13 +
 rtl/stream_out_reg.sv | 28 ++
 rtl/stream_width_packer.sv | 116 +++++++++++
 tb/tb_stream_width_packer.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_width_packer_pkg.sv
// Shared widths and helpers for the stream width packer.
// Imported by the packer top and its output register.
package stream_width_packer_pkg;

  localparam int DEF_IN_W  = 128;
  localparam int DEF_OUT_W = 512;

  // Bits needed to count the bytes of a w-bit beat.
  function automatic int clog2_bytes(input int w);
    return $clog2(w / 8);
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry output register with valid/ready hold.
// Loads a new beat only when the downstream slot is free.
module stream_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q
);

  // Hold the beat until it is taken; refill in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_width_packer.sv
// Packs RATIO narrow stream beats into one wide beat.
// Slot 0 sits in the LSBs; short packets pad with zeros.
module stream_width_packer
  import stream_width_packer_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_sop,
  input  logic                          in_eop,
  input  logic                          in_valid,
  input  logic [clog2_bytes(IN_W)-1:0]  in_empty,
  input  logic [IN_W-1:0]               in_data,
  output logic                          in_ready,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic                          out_valid,
  output logic [clog2_bytes(OUT_W)-1:0] out_empty,
  output logic [OUT_W-1:0]              out_data,
  input  logic                          out_ready,
  output logic                          err_sop
);

  localparam int RATIO  = OUT_W / IN_W;
  localparam int IN_EW  = clog2_bytes(IN_W);
  localparam int OUT_EW = clog2_bytes(OUT_W);
  localparam int SW     = $clog2(RATIO);
  localparam int IN_B   = IN_W / 8;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [OUT_EW-1:0] empty;
    logic [OUT_W-1:0]  data;
  } beat_t;

  logic [SW-1:0]     slot_cnt;
  logic [OUT_W-1:0]  acc;
  logic              acc_sop;
  logic              take;
  logic              restart;
  logic              fin;
  logic [SW-1:0]     slot;
  logic [OUT_W-1:0]  base;
  logic [OUT_W-1:0]  shifted;
  logic [OUT_EW-1:0] pad_b;
  beat_t             nxt;
  beat_t             cur;

  assign in_ready = !out_valid | out_ready;
  assign take     = in_valid & in_ready;

  // Place the incoming beat and build the candidate wide beat.
  always_comb begin
    restart   = in_sop & (slot_cnt != '0);
    slot      = in_sop ? '0 : slot_cnt;
    fin       = in_eop | (slot == SW'(RATIO - 1));
    base      = in_sop ? '0 : acc;
    shifted   = {{(OUT_W-IN_W){1'b0}}, in_data}
                << (slot * IN_W);
    pad_b     = OUT_EW'((RATIO - 1 - int'(slot))
                * IN_B);
    nxt.data  = base | shifted;
    nxt.sop   = in_sop | acc_sop;
    nxt.eop   = in_eop;
    nxt.empty = '0;
    if (in_eop)
      nxt.empty = pad_b
                + {{(OUT_EW-IN_EW){1'b0}}, in_empty};
  end

  // Accumulate non-final beats; clear once a beat is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      acc      <= '0;
      acc_sop  <= 1'b0;
    end else if (take) begin
      if (fin) begin
        slot_cnt <= '0;
        acc      <= '0;
        acc_sop  <= 1'b0;
      end else begin
        slot_cnt <= slot + 1'b1;
        acc      <= nxt.data;
        acc_sop  <= nxt.sop;
      end
    end
  end

  // Flag a partial packet cut short by a fresh sop.
  always_ff @(posedge clk) begin
    if (rst) err_sop <= 1'b0;
    else     err_sop <= take & restart;
  end

  stream_out_reg #(
    .W($bits(beat_t))
  ) u_out (
    .clk   (clk),
    .rst   (rst),
    .load  (take & fin),
    .d     (nxt),
    .ready (out_ready),
    .valid (out_valid),
    .q     (cur)
  );

  assign out_sop   = cur.sop;
  assign out_eop   = cur.eop;
  assign out_empty = cur.empty;
  assign out_data  = cur.data;

endmodule

// File: tb/tb_stream_width_packer.sv
// Randomised bench for stream_width_packer against a
// packet-level queue model; plus a narrow 64->256 instance.
module tb_stream_width_packer;

  localparam int IW  = 128;
  localparam int OW  = 512;
  localparam int EW  = 4;
  localparam int OEW = 6;
  localparam int R   = 4;

  logic clk = 0;
  logic rst = 1;
  logic in_sop = 0, in_eop = 0, in_valid = 0;
  logic [EW-1:0] in_empty = '0;
  logic [IW-1:0] in_data = '0;
  logic in_ready;
  logic out_sop, out_eop, out_valid, err_sop;
  logic [OEW-1:0] out_empty;
  logic [OW-1:0] out_data;
  logic out_ready = 1;

  logic s_rst = 1;
  logic s_sop = 0, s_eop = 0, s_valid = 0;
  logic [2:0] s_empty = '0;
  logic [63:0] s_data = '0;
  logic s_in_ready;
  logic s_out_sop, s_out_eop, s_out_valid, s_err;
  logic [4:0] s_out_empty;
  logic [255:0] s_out_data;
  logic s_out_ready = 1;

  stream_width_packer dut (
    .clk(clk), .rst(rst),
    .in_sop(in_sop), .in_eop(in_eop),
    .in_valid(in_valid), .in_empty(in_empty),
    .in_data(in_data), .in_ready(in_ready),
    .out_sop(out_sop), .out_eop(out_eop),
    .out_valid(out_valid), .out_empty(out_empty),
    .out_data(out_data), .out_ready(out_ready),
    .err_sop(err_sop)
  );

  stream_width_packer #(.IN_W(64), .OUT_W(256)) u_small (
    .clk(clk), .rst(s_rst),
    .in_sop(s_sop), .in_eop(s_eop),
    .in_valid(s_valid), .in_empty(s_empty),
    .in_data(s_data), .in_ready(s_in_ready),
    .out_sop(s_out_sop), .out_eop(s_out_eop),
    .out_valid(s_out_valid), .out_empty(s_out_empty),
    .out_data(s_out_data), .out_ready(s_out_ready),
    .err_sop(s_err)
  );

  typedef struct packed {
    logic           sop;
    logic           eop;
    logic [OEW-1:0] empty;
    logic [OW-1:0]  data;
  } beat_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  logic [IW-1:0] cur_q[$];
  bit cur_sop;
  int got_err, exp_err, stall_viol, rdy_viol, rdy_low;
  int n_checks, n_pass;
  int bp_mode;
  beat_t prev;
  bit prev_stall;

  initial forever #5 clk = ~clk;

  // Downstream backpressure patterns.
  initial forever begin
    @(posedge clk);
    #1;
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor + packet-level model, sampled mid-cycle.
  initial forever begin : mon
    beat_t b, e;
    logic [OW-1:0] tmp;
    @(negedge clk);
    b.sop = out_sop;
    b.eop = out_eop;
    b.empty = out_empty;
    b.data = out_data;
    if (rst) begin
      cur_q.delete();
      cur_sop = 0;
      prev_stall = 0;
    end else begin
      if (in_ready !== (!out_valid | out_ready))
        rdy_viol++;
      if (!in_ready) rdy_low++;
      if (prev_stall && b !== prev) stall_viol++;
      prev_stall = out_valid & !out_ready;
      prev = b;
      if (out_valid && out_ready) got_q.push_back(b);
      if (err_sop) got_err++;
      if (in_valid && in_ready) begin
        if (in_sop) begin
          if (cur_q.size() != 0) exp_err++;
          cur_q.delete();
          cur_sop = 1;
        end
        cur_q.push_back(in_data);
        if (in_eop || cur_q.size() == R) begin
          e.data = '0;
          foreach (cur_q[i]) begin
            tmp = OW'(cur_q[i]);
            e.data = e.data | (tmp << (i * IW));
          end
          e.sop = cur_sop;
          e.eop = in_eop;
          e.empty = '0;
          if (in_eop)
            e.empty = OEW'((R - cur_q.size()) * (IW / 8))
                    + OEW'(in_empty);
          exp_q.push_back(e);
          cur_q.delete();
          cur_sop = 0;
        end
      end
    end
  end

  function automatic logic [IW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    got_err = 0;
    exp_err = 0;
    stall_viol = 0;
    rdy_viol = 0;
    rdy_low = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until accepted.
  task automatic send(input bit s, input bit e,
                      input logic [EW-1:0] em,
                      input logic [IW-1:0] d);
    int t;
    t = 0;
    in_valid = 1;
    in_sop = s;
    in_eop = e;
    in_empty = em;
    in_data = d;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout in_ready=%0b need 1",
               in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    in_sop = 1'($urandom_range(0, 1));
    in_eop = 1'($urandom_range(0, 1));
    in_empty = EW'($urandom);
    in_data = rnd();
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (t < 400 && (out_valid ||
           got_q.size() < exp_q.size())) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      n_checks++;
      $display("FAIL %s drain_timeout got=%0d need=%0d",
               nm, got_q.size(), exp_q.size());
    end
    idle(2);
  endtask

  task automatic cmp_model(input string nm);
    n_checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s beat_count got=%0d exp=%0d",
               nm, got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size())
        $display("FAIL %s beat%0d missing", nm, i);
      else if (got_q[i] !== exp_q[i])
        $display("FAIL %s beat%0d got=%h exp=%h",
                 nm, i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    in_valid = 1;
    in_sop = 1;
    in_eop = 1;
    in_data = rnd();
    idle(3);
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_sop, out_eop, err_sop} !== 4'b0)
      $display("FAIL reset_flags got=%b exp=0000",
               {out_valid, out_sop, out_eop, err_sop});
    else n_pass++;
    n_checks++;
    if (out_data !== '0 || out_empty !== '0)
      $display("FAIL reset_data got=%h/%h exp=0",
               out_data, out_empty);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 0;
    rst = 0;
    clear_sb();
    idle(3);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || got_q.size() != 0)
      $display("FAIL reset_discard got=%b exp=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [OW-1:0] x0, x1;
    clear_sb();
    bp_mode = 0;
    for (int i = 1; i <= 8; i++)
      send(i == 1, i == 8, '0, IW'(i));
    drain("basic");
    cmp_model("basic");
    x0 = {128'd4, 128'd3, 128'd2, 128'd1};
    x1 = {128'd8, 128'd7, 128'd6, 128'd5};
    if (got_q.size() == 2) begin
      n_checks++;
      if (got_q[0] !== {1'b1, 1'b0, 6'd0, x0})
        $display("FAIL basic_b0 got=%h", got_q[0]);
      else n_pass++;
      n_checks++;
      if (got_q[1] !== {1'b0, 1'b1, 6'd0, x1})
        $display("FAIL basic_b1 got=%h", got_q[1]);
      else n_pass++;
    end
  endtask

  task automatic test_partial();
    logic [IW-1:0] d[5];
    clear_sb();
    for (int i = 0; i < 5; i++) d[i] = rnd();
    for (int i = 0; i < 5; i++)
      send(i == 0, i == 4, (i == 4) ? 4'd4 : 4'd0, d[i]);
    drain("partial");
    cmp_model("partial");
    n_checks++;
    if (got_q.size() != 2 || got_q[1] !==
        {1'b0, 1'b1, 6'd52, {384'd0, d[4]}})
      $display("FAIL partial_tail got=%0d beats need 2",
               got_q.size());
    else n_pass++;
  endtask

  task automatic test_single();
    logic [IW-1:0] d;
    clear_sb();
    d = rnd();
    send(1, 1, 4'd15, d);
    drain("single");
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !==
        {1'b1, 1'b1, 6'd63, {384'd0, d}})
      $display("FAIL single got=%0d beats need 1",
               got_q.size());
    else n_pass++;
  endtask

  task automatic test_drop();
    logic [IW-1:0] d;
    clear_sb();
    d = rnd();
    send(1, 0, 0, rnd());
    send(0, 0, 0, rnd());
    send(1, 1, 0, d);
    drain("drop");
    n_checks++;
    if (got_err !== 1)
      $display("FAIL drop_err got=%0d exp=1", got_err);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !==
        {1'b1, 1'b1, 6'd48, {384'd0, d}})
      $display("FAIL drop_beat got=%0d beats need 1",
               got_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int lens[3];
    clear_sb();
    lens = '{6, 4, 9};
    bp_mode = 1;
    foreach (lens[p])
      for (int i = 0; i < lens[p]; i++)
        send(i == 0, i == lens[p] - 1, EW'($urandom), rnd());
    drain("bp");
    bp_mode = 0;
    cmp_model("bp");
    n_checks++;
    if (stall_viol !== 0 || rdy_viol !== 0)
      $display("FAIL bp_hold got=%0d/%0d exp=0/0",
               stall_viol, rdy_viol);
    else n_pass++;
    n_checks++;
    if (rdy_low == 0)
      $display("FAIL bp_stall got=%0d need>0", rdy_low);
    else n_pass++;
  endtask

  task automatic test_random();
    int len;
    bit cut;
    clear_sb();
    bp_mode = 2;
    for (int p = 0; p < 14; p++) begin
      len = $urandom_range(1, 10);
      cut = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) begin
        send(i == 0, !cut && i == len - 1,
             EW'($urandom), rnd());
        if ($urandom_range(0, 4) == 0)
          idle($urandom_range(1, 3));
      end
    end
    drain("rand");
    bp_mode = 0;
    cmp_model("rand");
    n_checks++;
    if (got_err !== exp_err)
      $display("FAIL rand_err got=%0d exp=%0d",
               got_err, exp_err);
    else n_pass++;
    n_checks++;
    if (stall_viol !== 0 || rdy_viol !== 0)
      $display("FAIL rand_hold got=%0d/%0d exp=0/0",
               stall_viol, rdy_viol);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    clear_sb();
    send(1, 0, 0, rnd());
    send(0, 0, 0, rnd());
    rst = 1;
    idle(1);
    rst = 0;
    for (int i = 0; i < 4; i++)
      send(i == 0, i == 3, 0, rnd());
    drain("rmid");
    cmp_model("rmid");
    n_checks++;
    if (got_err !== 0)
      $display("FAIL rmid_err got=%0d exp=0", got_err);
    else n_pass++;
    bp_mode = 3;
    idle(1);
    for (int i = 0; i < 4; i++)
      send(i == 0, i == 3, 0, rnd());
    idle(2);
    rst = 1;
    idle(1);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL rheld_valid got=%b exp=0", out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 0;
    bp_mode = 0;
    clear_sb();
    idle(4);
    n_checks++;
    if (got_q.size() != 0)
      $display("FAIL rheld_out got=%0d exp=0", got_q.size());
    else n_pass++;
  endtask

  task automatic test_small();
    logic [63:0] b[4];
    logic [255:0] sd;
    int cnt;
    logic so, eo;
    logic [4:0] se;
    cnt = 0;
    sd = '0;
    so = 0;
    eo = 0;
    se = '1;
    for (int i = 0; i < 4; i++)
      b[i] = {$urandom, $urandom};
    s_rst = 0;
    fork
      begin
        s_valid = 1;
        s_sop = 1;
        s_data = {$urandom, $urandom};
        idle(1);
        s_sop = 0;
        s_data = {$urandom, $urandom};
        idle(1);
        s_valid = 0;
        s_rst = 1;
        idle(1);
        s_rst = 0;
        for (int i = 0; i < 4; i++) begin
          s_valid = 1;
          s_sop = (i == 0);
          s_eop = (i == 3);
          s_data = b[i];
          idle(1);
        end
        s_valid = 0;
        s_eop = 0;
      end
      begin
        repeat (14) begin
          @(negedge clk);
          if (!s_rst && s_out_valid && s_out_ready) begin
            cnt++;
            sd = s_out_data;
            so = s_out_sop;
            eo = s_out_eop;
            se = s_out_empty;
          end
        end
      end
    join
    n_checks++;
    if (cnt !== 1)
      $display("FAIL small_count got=%0d exp=1", cnt);
    else n_pass++;
    n_checks++;
    if (sd !== {b[3], b[2], b[1], b[0]})
      $display("FAIL small_data got=%h exp=%h",
               sd, {b[3], b[2], b[1], b[0]});
    else n_pass++;
    n_checks++;
    if ({so, eo, se} !== {1'b1, 1'b1, 5'd0})
      $display("FAIL small_flags got=%b exp=1100000",
               {so, eo, se});
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    bp_mode = 0;
    clear_sb();
    test_reset();
    test_basic();
    test_partial();
    test_single();
    test_drop();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_small();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
